// File: rtl/count_to_60_bcd.sv
// count_to_60_bcd: two-digit BCD modulo-60 counter with combinational wrap carry
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset, overrides ena
//   ena   - count enable pulse from the upstream stage
//   out   - carry, high while ena=1 and q is at the terminal count
//   q     - BCD count, [7:4] tens digit, [3:0] ones digit
module count_to_60_bcd #(
  parameter int TENS_MAX = 5,
  parameter int ONES_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  output logic       out,
  output logic [7:0] q
);
  localparam logic [3:0] TM = 4'(TENS_MAX);
  localparam logic [3:0] OM = 4'(ONES_MAX);
  localparam logic [7:0] TERM = {TM, OM};
  logic [3:0] tens, ones;
  logic [7:0] nxt;
  assign tens = q[7:4];
  assign ones = q[3:0];
  assign out = ena & ~reset & (q == TERM);
  // terminal count and any out-of-range code both restart at 00
  always_comb
    nxt = (tens > TM || ones > OM || q == TERM) ? 8'h00 :
          (ones < OM) ? {tens, ones + 4'd1} : {tens + 4'd1, 4'd0};
  always_ff @(posedge clk)
    if (reset) q <= 8'h00;
    else if (ena) q <= nxt;
endmodule

// File: tb/tb_count_to_60_bcd.sv
// tb_count_to_60_bcd: directed self-checking bench for count_to_60_bcd
module tb_count_to_60_bcd;
  logic clk = 0, reset = 0, ena = 0, out;
  logic [7:0] q;
  int tests = 0, fails = 0, carries = 0;
  count_to_60_bcd dut (.clk(clk), .reset(reset), .ena(ena), .out(out), .q(q));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] bcd(input int n);
    return 8'(((n % 60) / 10) * 16 + (n % 10));
  endfunction
  task automatic do_reset;
    @(negedge clk);
    reset = 1;
    ena = 0;
    @(negedge clk);
    reset = 0;
  endtask
  task automatic pulse;
    @(negedge clk);
    ena = 1;
    #1 if (out === 1'b1) carries++;
    @(negedge clk);
    ena = 0;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    reset = 1;
    #1 chk("rst_out", 8'(out), 8'h00);
    @(negedge clk);
    chk("rst_q", q, 8'h00);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("hold_q", q, 8'h00);
    chk("hold_out", 8'(out), 8'h00);
    for (int i = 1; i <= 10; i++) begin
      pulse();
      chk($sformatf("cnt_%0d", i), q, bcd(i));
    end
    chk("cnt_10", q, 8'h10);
    do_reset();
    repeat (59) pulse();
    chk("wrap_q59", q, 8'h59);
    chk("wrap_idle_out", 8'(out), 8'h00);
    @(negedge clk);
    ena = 1;
    #1 chk("wrap_carry", 8'(out), 8'h01);
    @(negedge clk);
    ena = 0;
    #1 chk("wrap_carry_drop", 8'(out), 8'h00);
    chk("wrap_q00", q, 8'h00);
    do_reset();
    repeat (59) pulse();
    chk("prio_q59", q, 8'h59);
    @(negedge clk);
    ena = 1;
    reset = 1;
    #1 chk("prio_out", 8'(out), 8'h00);
    @(negedge clk);
    ena = 0;
    reset = 0;
    chk("prio_q", q, 8'h00);
    do_reset();
    repeat (37) pulse();
    chk("mid_q37", q, 8'h37);
    do_reset();
    chk("mid_rst", q, 8'h00);
    pulse();
    chk("mid_resume", q, 8'h01);
    do_reset();
    carries = 0;
    for (int i = 1; i <= 180; i++) begin
      pulse();
      chk($sformatf("long_%0d", i), q, bcd(i));
      chk("long_bcd", 8'(q[3:0] <= 4'd9 && q <= 8'h59), 8'h01);
    end
    chk("long_carries", 8'(carries), 8'd3);
    chk("long_final", q, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
